// File: rtl/check_node_serial.sv
// Serial phi-domain LDPC check-node update: collects DC variable-to-check messages,
// then emits DC extrinsic check-to-variable messages in arrival order.

// phi(x) = -ln(tanh(x/2)), 6-bit unsigned 2.4 in -> 4-bit unsigned 2.2 out, rounded to nearest.
module phi_lut (
  input  logic [5:0] x_i,
  output logic [3:0] y_o
);
  always_comb begin
    if      (x_i == 6'd0)  y_o = 4'd15;
    else if (x_i == 6'd1)  y_o = 4'd14;
    else if (x_i == 6'd2)  y_o = 4'd11;
    else if (x_i == 6'd3)  y_o = 4'd9;
    else if (x_i == 6'd4)  y_o = 4'd8;
    else if (x_i <= 6'd6)  y_o = 4'd7;
    else if (x_i <= 6'd8)  y_o = 4'd6;
    else if (x_i <= 6'd10) y_o = 4'd5;
    else if (x_i <= 6'd14) y_o = 4'd4;
    else if (x_i <= 6'd19) y_o = 4'd3;
    else if (x_i <= 6'd26) y_o = 4'd2;
    else if (x_i <= 6'd44) y_o = 4'd1;
    else                   y_o = 4'd0;
  end
endmodule

module check_node_serial #(
  parameter int DC    = 6,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_sign_i,
  input  logic [5:0]       in_mag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_sign_o,
  output logic [5:0]       out_mag_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o
);
  localparam int SW = 4 + $clog2(DC);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_EMIT    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [SW-1:0]    s_q, s_d;
  logic             parity_q, parity_d;

  logic [3:0]       buf_phi_q [DC];
  logic [DC-1:0]    buf_sgn_q;

  logic [3:0]       in_phi;
  logic [3:0]       out_phi;
  logic [SW-1:0]    diff;
  logic [5:0]       lut_x;
  logic             in_fire, out_fire, last_edge;

  phi_lut u_phi_in  (.x_i(in_mag_i), .y_o(in_phi));
  phi_lut u_phi_out (.x_i(lut_x),    .y_o(out_phi));

  assign in_ready_o  = (state_q == ST_COLLECT);
  assign out_valid_o = (state_q == ST_EMIT);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign last_edge   = (count_q == IDX_W'(DC - 1));

  // Extrinsic magnitude: remove this edge's own phi from the sum, saturate back into 2.4.
  assign diff       = s_q - SW'(buf_phi_q[count_q]);
  assign lut_x      = (diff > SW'(15)) ? 6'd63 : {diff[3:0], 2'b00};
  assign out_mag_o  = {out_phi, 2'b00};
  assign out_sign_o = parity_q ^ buf_sgn_q[count_q];
  assign out_idx_o  = count_q;
  assign out_last_o = out_valid_o & last_edge;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    count_d  = count_q;
    s_d      = s_q;
    parity_d = parity_q;
    case (state_q)
      ST_COLLECT: begin
        if (in_fire) begin
          s_d      = s_q + SW'(in_phi);
          parity_d = parity_q ^ in_sign_i;
          if (last_edge) begin
            count_d = '0;
            state_d = ST_EMIT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        if (out_fire) begin
          if (last_edge) begin
            state_d  = ST_COLLECT;
            count_d  = '0;
            s_d      = '0;
            parity_d = 1'b0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_COLLECT;
      count_q  <= '0;
      s_q      <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      s_q      <= s_d;
      parity_q <= parity_d;
    end
  end

  // NOTE: the message buffer is not reset; every entry is rewritten before it is read in a frame.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_phi_q[count_q] <= in_phi;
      buf_sgn_q[count_q] <= in_sign_i;
    end
  end

endmodule

// File: tb/tb_check_node_serial.sv
// Directed self-checking bench for check_node_serial (DC=6): frame-level vectors with
// hand-computed phi-domain results, including stall and mid-frame reset.
module tb_check_node_serial;
  localparam int DC    = 6;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [5:0]       in_mag;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [5:0]       out_mag;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  int checks   = 0;
  int failures = 0;

  logic [5:0] v_mag [DC];
  logic       v_sgn [DC];
  logic [5:0] e_mag [DC];
  logic       e_sgn [DC];

  always #5 clk = ~clk;

  check_node_serial #(.DC(DC), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_sign_i  (in_sign),
    .in_mag_i   (in_mag),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sign_o (out_sign),
    .out_mag_o  (out_mag),
    .out_idx_o  (out_idx),
    .out_last_o (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one frame from v_mag/v_sgn, one message per cycle; outputs are sampled on negedges.
  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("in_ready_push%0d", i), in_ready, 1);
      chk($sformatf("out_valid_push%0d", i), out_valid, 0);
      in_valid = 1'b1;
      in_mag   = v_mag[i];
      in_sign  = v_sgn[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consume one frame, comparing against e_mag/e_sgn; in_valid is held high with junk to prove it is ignored.
  task automatic drain_frame(input int stall_idx);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mag    = 6'd0;
    in_sign   = 1'b1;
    for (int j = 0; j < DC; j++) begin
      if (j == stall_idx) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("stall%0d_valid", k), out_valid, 1);
          chk($sformatf("stall%0d_idx", k), out_idx, j);
          chk($sformatf("stall%0d_mag", k), out_mag, e_mag[j]);
          chk($sformatf("stall%0d_sign", k), out_sign, e_sgn[j]);
          chk($sformatf("stall%0d_in_ready", k), in_ready, 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("out_valid_e%0d", j), out_valid, 1);
      chk($sformatf("in_ready_e%0d", j), in_ready, 0);
      chk($sformatf("out_idx_e%0d", j), out_idx, j);
      chk($sformatf("out_mag_e%0d", j), out_mag, e_mag[j]);
      chk($sformatf("out_sign_e%0d", j), out_sign, e_sgn[j]);
      chk($sformatf("out_last_e%0d", j), out_last, (j == DC - 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("post_frame_out_valid", out_valid, 0);
    chk("post_frame_in_ready", in_ready, 1);
    chk("post_frame_idx", out_idx, 0);
  endtask

  task automatic set_vec(input int m0, m1, m2, m3, m4, m5, input logic [5:0] s);
    v_mag[0] = 6'(m0); v_mag[1] = 6'(m1); v_mag[2] = 6'(m2);
    v_mag[3] = 6'(m3); v_mag[4] = 6'(m4); v_mag[5] = 6'(m5);
    for (int i = 0; i < DC; i++) v_sgn[i] = s[i];
  endtask

  task automatic set_exp(input int m0, m1, m2, m3, m4, m5, input logic [5:0] s);
    e_mag[0] = 6'(m0); e_mag[1] = 6'(m1); e_mag[2] = 6'(m2);
    e_mag[3] = 6'(m3); e_mag[4] = 6'(m4); e_mag[5] = 6'(m5);
    for (int i = 0; i < DC; i++) e_sgn[i] = s[i];
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_mag    = 6'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_idx", out_idx, 0);
    rst = 1'b0;

    // Weak inputs: S=0, every D=0 -> 3.75.
    set_vec(63, 63, 63, 63, 63, 63, 6'b000000);
    set_exp(60, 60, 60, 60, 60, 60, 6'b000000);
    push_frame(DC);
    drain_frame(-1);

    // One strong edge: S=15, own edge D=0, others D=15 -> X=60 -> 0.
    set_vec(0, 63, 63, 63, 63, 63, 6'b000000);
    set_exp(60, 0, 0, 0, 0, 0, 6'b000000);
    push_frame(DC);
    drain_frame(-1);

    // Sign on edge 0 only: parity=1, extrinsic signs 0,1,1,1,1,1 (bit i = edge i).
    set_vec(63, 63, 63, 63, 63, 63, 6'b000001);
    set_exp(60, 60, 60, 60, 60, 60, 6'b111110);
    push_frame(DC);
    drain_frame(-1);

    // All strong: S=90, D=75 saturates to X=63 -> 0.
    set_vec(0, 0, 0, 0, 0, 0, 6'b000000);
    set_exp(0, 0, 0, 0, 0, 0, 6'b000000);
    push_frame(DC);
    drain_frame(-1);

    // Mixed: phi = 3,1,6,0,0,0, S=10, parity=1; D = 7,9,4,10,10,10 -> X = 28,36,16,40,40,40.
    set_vec(16, 32, 8, 63, 63, 63, 6'b100110);
    set_exp(4, 4, 12, 4, 4, 4, 6'b011001);
    push_frame(DC);
    drain_frame(-1);

    // Downstream stall of 3 cycles on idx 2.
    set_vec(16, 32, 8, 63, 63, 63, 6'b100110);
    set_exp(4, 4, 12, 4, 4, 4, 6'b011001);
    push_frame(DC);
    drain_frame(2);

    // Reset after 3 accepted inputs, then a fresh frame of weak messages.
    set_vec(0, 0, 0, 0, 0, 0, 6'b111111);
    push_frame(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_idx", out_idx, 0);
    set_vec(63, 63, 63, 63, 63, 63, 6'b000000);
    set_exp(60, 60, 60, 60, 60, 60, 6'b000000);
    push_frame(DC);
    drain_frame(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
